// File: rtl/axi_req_spill_cut.sv
// Two-entry skid buffer (register cut) on Ariane AXI request/response structs.
// Every channel (AW, W, B, AR, R) gets an independent two-slot buffer that
// registers valid, ready and payload, giving one beat per cycle per channel
// with one cycle of forward latency. Clearing a CutMask bit turns that
// channel into plain wires.

package ariane_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
  } aw_chan_t;

  typedef aw_chan_t ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// One valid/ready channel: either a two-slot registered cut or straight wires.
module axi_req_spill_cut_chan #(
  parameter int unsigned Width = 1,
  parameter bit          Cut   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  if (Cut) begin : g_cut
    // Encoding chosen so bit 0 is the A-slot full flag and bit 1 the S-slot
    // full flag; both handshake outputs then come straight from flops.
    typedef enum logic [1:0] {
      EMPTY = 2'b00,
      HALF  = 2'b01,
      FULL  = 2'b11
    } state_e;

    state_e           state;
    logic [Width-1:0] a_data;
    logic [Width-1:0] s_data;
    logic             in_hs;
    logic             out_hs;

    assign in_ready  = ~state[1];
    assign out_valid = state[0];
    assign out_data  = a_data;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    // Slot occupancy and payload movement between input, spill and output slots.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values and
      // a beat moving S->A in the same edge as A drains cannot race.
      if (!rst_ni) begin
        state  <= EMPTY;
        // NOTE: only the full flags matter functionally; payload is also cleared so the
        // outputs never carry X after reset.
        a_data <= '0;
        s_data <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (in_hs) begin
              a_data <= in_data;
              state  <= HALF;
            end
          end
          HALF: begin
            if (out_hs) begin
              // Drain and refill in the same edge keeps the stream bubble-free.
              if (in_hs) a_data <= in_data;
              else       state  <= EMPTY;
            end else if (in_hs) begin
              s_data <= in_data;
              state  <= FULL;
            end
          end
          FULL: begin
            if (out_hs) begin
              a_data <= s_data;
              state  <= HALF;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end else begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
  end

endmodule

module axi_req_spill_cut #(
  parameter type        req_t   = ariane_axi::req_t,
  parameter type        resp_t  = ariane_axi::resp_t,
  // {AW, W, B, AR, R}; a 0 bit makes that channel combinational.
  parameter logic [4:0] CutMask = 5'b11111
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i
);

  localparam int unsigned AwWidth = $bits(slv_req_i.aw);
  localparam int unsigned WWidth  = $bits(slv_req_i.w);
  localparam int unsigned BWidth  = $bits(mst_resp_i.b);
  localparam int unsigned ArWidth = $bits(slv_req_i.ar);
  localparam int unsigned RWidth  = $bits(mst_resp_i.r);

  logic               aw_in_ready, aw_out_valid;
  logic [AwWidth-1:0] aw_out_data;
  logic               w_in_ready, w_out_valid;
  logic [WWidth-1:0]  w_out_data;
  logic               b_in_ready, b_out_valid;
  logic [BWidth-1:0]  b_out_data;
  logic               ar_in_ready, ar_out_valid;
  logic [ArWidth-1:0] ar_out_data;
  logic               r_in_ready, r_out_valid;
  logic [RWidth-1:0]  r_out_data;

  axi_req_spill_cut_chan #(.Width(AwWidth), .Cut(CutMask[4])) i_aw (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (slv_req_i.aw_valid),
    .in_ready  (aw_in_ready),
    .in_data   (slv_req_i.aw),
    .out_valid (aw_out_valid),
    .out_ready (mst_resp_i.aw_ready),
    .out_data  (aw_out_data)
  );

  axi_req_spill_cut_chan #(.Width(WWidth), .Cut(CutMask[3])) i_w (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (slv_req_i.w_valid),
    .in_ready  (w_in_ready),
    .in_data   (slv_req_i.w),
    .out_valid (w_out_valid),
    .out_ready (mst_resp_i.w_ready),
    .out_data  (w_out_data)
  );

  axi_req_spill_cut_chan #(.Width(BWidth), .Cut(CutMask[2])) i_b (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (mst_resp_i.b_valid),
    .in_ready  (b_in_ready),
    .in_data   (mst_resp_i.b),
    .out_valid (b_out_valid),
    .out_ready (slv_req_i.b_ready),
    .out_data  (b_out_data)
  );

  axi_req_spill_cut_chan #(.Width(ArWidth), .Cut(CutMask[1])) i_ar (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (slv_req_i.ar_valid),
    .in_ready  (ar_in_ready),
    .in_data   (slv_req_i.ar),
    .out_valid (ar_out_valid),
    .out_ready (mst_resp_i.ar_ready),
    .out_data  (ar_out_data)
  );

  axi_req_spill_cut_chan #(.Width(RWidth), .Cut(CutMask[0])) i_r (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (mst_resp_i.r_valid),
    .in_ready  (r_in_ready),
    .in_data   (mst_resp_i.r),
    .out_valid (r_out_valid),
    .out_ready (slv_req_i.r_ready),
    .out_data  (r_out_data)
  );

  // Reassemble the request/response structs from the per-channel buffers.
  always_comb begin
    // NOTE: the whole struct gets a default first so no field can infer a latch.
    mst_req_o          = '0;
    mst_req_o.aw       = aw_out_data;
    mst_req_o.aw_valid = aw_out_valid;
    mst_req_o.w        = w_out_data;
    mst_req_o.w_valid  = w_out_valid;
    mst_req_o.b_ready  = b_in_ready;
    mst_req_o.ar       = ar_out_data;
    mst_req_o.ar_valid = ar_out_valid;
    mst_req_o.r_ready  = r_in_ready;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_in_ready;
    slv_resp_o.w_ready  = w_in_ready;
    slv_resp_o.b        = b_out_data;
    slv_resp_o.b_valid  = b_out_valid;
    slv_resp_o.ar_ready = ar_in_ready;
    slv_resp_o.r        = r_out_data;
    slv_resp_o.r_valid  = r_out_valid;
  end

endmodule

// File: tb/tb_axi_req_spill_cut.sv
// Directed and randomised bench for axi_req_spill_cut: reset, latency,
// backpressure, streaming, random scoreboard, bypass and mid-stream reset.
module tb_axi_req_spill_cut;
  import ariane_axi::*;

  logic  clk = 1'b0;
  logic  rst_n;
  req_t  slv_req;
  resp_t slv_resp;
  req_t  mst_req;
  resp_t mst_resp;
  resp_t slv_resp_b;
  req_t  mst_req_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_req_spill_cut dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  axi_req_spill_cut #(.CutMask(5'b01111)) dut_byp (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp_b),
    .mst_req_o  (mst_req_b),
    .mst_resp_i (mst_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    slv_req  = '0;
    mst_resp = '0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    slv_req  = '0;
    mst_resp = '0;
    slv_req.aw_valid  = 1'b1;
    slv_req.w_valid   = 1'b1;
    slv_req.ar_valid  = 1'b1;
    mst_resp.b_valid  = 1'b1;
    mst_resp.r_valid  = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mst_req.aw_valid !== 1'b0) begin
      failures++; $display("FAIL reset_aw_valid: got %b expected 0", mst_req.aw_valid);
    end
    checks++;
    if (slv_resp.aw_ready !== 1'b1) begin
      failures++; $display("FAIL reset_aw_ready: got %b expected 1", slv_resp.aw_ready);
    end
    checks++;
    if ({mst_req.w_valid, mst_req.ar_valid, slv_resp.b_valid, slv_resp.r_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_valids: got %b expected 0000",
               {mst_req.w_valid, mst_req.ar_valid, slv_resp.b_valid, slv_resp.r_valid});
    end
    checks++;
    if ({slv_resp.w_ready, slv_resp.ar_ready, mst_req.b_ready, mst_req.r_ready} !== 4'b1111) begin
      failures++;
      $display("FAIL reset_readys: got %b expected 1111",
               {slv_resp.w_ready, slv_resp.ar_ready, mst_req.b_ready, mst_req.r_ready});
    end
    checks++;
    if (mst_req.aw !== aw_chan_t'('0)) begin
      failures++; $display("FAIL reset_aw_payload: got %h expected 0", mst_req.aw);
    end
    slv_req  = '0;
    mst_resp = '0;
    rst_n    = 1'b1;
    tick();
    checks++;
    if ({mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
         slv_resp.b_valid, slv_resp.r_valid} !== 5'b00000) begin
      failures++;
      $display("FAIL release_valids: got %b expected 00000",
               {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid, slv_resp.b_valid, slv_resp.r_valid});
    end
  endtask

  task automatic test_latency();
    mst_resp.aw_ready = 1'b1;
    slv_req.aw_valid  = 1'b1;
    slv_req.aw.addr   = 64'h0000_0000_8000_0000;
    slv_req.aw.id     = 4'd3;
    #1;
    checks++;
    if (mst_req.aw_valid !== 1'b0) begin
      failures++; $display("FAIL lat_same_cycle_valid: got %b expected 0", mst_req.aw_valid);
    end
    tick();
    slv_req.aw_valid = 1'b0;
    #1;
    checks++;
    if (mst_req.aw_valid !== 1'b1) begin
      failures++; $display("FAIL lat_aw_valid: got %b expected 1", mst_req.aw_valid);
    end
    checks++;
    if (mst_req.aw.addr !== 64'h0000_0000_8000_0000) begin
      failures++; $display("FAIL lat_aw_addr: got %h expected 80000000", mst_req.aw.addr);
    end
    checks++;
    if (mst_req.aw.id !== 4'd3) begin
      failures++; $display("FAIL lat_aw_id: got %0d expected 3", mst_req.aw.id);
    end
    checks++;
    if (slv_resp.aw_ready !== 1'b1) begin
      failures++; $display("FAIL lat_aw_ready: got %b expected 1", slv_resp.aw_ready);
    end
    tick();
    checks++;
    if (mst_req.aw_valid !== 1'b0) begin
      failures++; $display("FAIL lat_aw_drained: got %b expected 0", mst_req.aw_valid);
    end
  endtask

  task automatic test_backpressure();
    mst_resp.w_ready = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 64'hA;
    #1;
    checks++;
    if (slv_resp.w_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_a: got %b expected 1", slv_resp.w_ready);
    end
    tick();
    slv_req.w.data = 64'hB;
    #1;
    checks++;
    if (slv_resp.w_ready !== 1'b1 || mst_req.w_valid !== 1'b1 || mst_req.w.data !== 64'hA) begin
      failures++;
      $display("FAIL bp_after_a: got ready=%b valid=%b data=%h expected ready=1 valid=1 data=a",
               slv_resp.w_ready, mst_req.w_valid, mst_req.w.data);
    end
    tick();
    slv_req.w.data = 64'hC;
    #1;
    checks++;
    if (slv_resp.w_ready !== 1'b0 || mst_req.w.data !== 64'hA) begin
      failures++;
      $display("FAIL bp_full: got ready=%b data=%h expected ready=0 data=a",
               slv_resp.w_ready, mst_req.w.data);
    end
    tick();
    checks++;
    if (slv_resp.w_ready !== 1'b0 || mst_req.w_valid !== 1'b1 || mst_req.w.data !== 64'hA) begin
      failures++;
      $display("FAIL bp_stall_stable: got ready=%b valid=%b data=%h expected ready=0 valid=1 data=a",
               slv_resp.w_ready, mst_req.w_valid, mst_req.w.data);
    end
    mst_resp.w_ready = 1'b1;
    #1;
    checks++;
    if (slv_resp.w_ready !== 1'b0) begin
      failures++; $display("FAIL bp_no_comb_ready: got %b expected 0", slv_resp.w_ready);
    end
    tick();
    checks++;
    if (mst_req.w_valid !== 1'b1 || mst_req.w.data !== 64'hB || slv_resp.w_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_out_b: got valid=%b data=%h ready=%b expected valid=1 data=b ready=1",
               mst_req.w_valid, mst_req.w.data, slv_resp.w_ready);
    end
    tick();
    slv_req.w_valid = 1'b0;
    #1;
    checks++;
    if (mst_req.w_valid !== 1'b1 || mst_req.w.data !== 64'hC) begin
      failures++;
      $display("FAIL bp_out_c: got valid=%b data=%h expected valid=1 data=c",
               mst_req.w_valid, mst_req.w.data);
    end
    tick();
    checks++;
    if (mst_req.w_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drained: got %b expected 0", mst_req.w_valid);
    end
  endtask

  task automatic test_streaming();
    slv_req.r_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data  = 64'(i);
        mst_resp.r.last  = (i == 7);
      end else begin
        mst_resp.r_valid = 1'b0;
      end
      #1;
      checks++;
      if (mst_req.r_ready !== 1'b1) begin
        failures++; $display("FAIL stream_r_ready beat %0d: got %b expected 1", i, mst_req.r_ready);
      end
      if (i > 0) begin
        checks++;
        if (slv_resp.r_valid !== 1'b1 || slv_resp.r.data !== 64'(i - 1) ||
            slv_resp.r.last !== (i == 8)) begin
          failures++;
          $display("FAIL stream_beat %0d: got valid=%b data=%0d last=%b expected valid=1 data=%0d last=%b",
                   i - 1, slv_resp.r_valid, slv_resp.r.data, slv_resp.r.last, i - 1, (i == 8));
        end
      end
      tick();
    end
    checks++;
    if (slv_resp.r_valid !== 1'b0) begin
      failures++; $display("FAIL stream_end: got %b expected 0", slv_resp.r_valid);
    end
  endtask

  // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R.
  task automatic test_random();
    logic [63:0] fifo [5][8];
    logic [63:0] src_key [5];
    logic [63:0] out_key [5];
    logic [63:0] held_key [5];
    logic        src_vld [5];
    logic        snk_rdy [5];
    logic        in_rdy [5];
    logic        out_vld [5];
    logic        stall [5];
    logic        acc [5];
    int          wp [5];
    int          rp [5];
    int          xfers [5];
    int unsigned cnt [5];
    int          sb_err   = 0;
    int          stab_err = 0;
    apply_reset();
    for (int ch = 0; ch < 5; ch++) begin
      src_vld[ch] = 1'b0; snk_rdy[ch] = 1'b0; stall[ch] = 1'b0; acc[ch] = 1'b0;
      src_key[ch] = '0; held_key[ch] = '0;
      wp[ch] = 0; rp[ch] = 0; xfers[ch] = 0; cnt[ch] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int ch = 0; ch < 5; ch++) begin
        if (!src_vld[ch] || acc[ch]) begin
          src_vld[ch] = ($urandom_range(0, 3) != 0);
          if (src_vld[ch]) begin
            src_key[ch] = (ch == 2) ? 64'(cnt[ch] & 63) : 64'(cnt[ch]);
            cnt[ch]++;
          end
        end
        snk_rdy[ch] = ($urandom_range(0, 2) != 0);
      end
      slv_req.aw_valid  = src_vld[0]; slv_req.aw.addr = src_key[0]; slv_req.aw.id = src_key[0][3:0];
      slv_req.w_valid   = src_vld[1]; slv_req.w.data  = src_key[1]; slv_req.w.last = src_key[1][0];
      mst_resp.b_valid  = src_vld[2]; mst_resp.b.id   = src_key[2][3:0]; mst_resp.b.resp = src_key[2][5:4];
      slv_req.ar_valid  = src_vld[3]; slv_req.ar.addr = src_key[3];
      mst_resp.r_valid  = src_vld[4]; mst_resp.r.data = src_key[4]; mst_resp.r.last = src_key[4][0];
      mst_resp.aw_ready = snk_rdy[0];
      mst_resp.w_ready  = snk_rdy[1];
      slv_req.b_ready   = snk_rdy[2];
      mst_resp.ar_ready = snk_rdy[3];
      slv_req.r_ready   = snk_rdy[4];
      #1;
      in_rdy[0] = slv_resp.aw_ready; out_vld[0] = mst_req.aw_valid; out_key[0] = mst_req.aw.addr;
      in_rdy[1] = slv_resp.w_ready;  out_vld[1] = mst_req.w_valid;  out_key[1] = mst_req.w.data;
      in_rdy[2] = mst_req.b_ready;   out_vld[2] = slv_resp.b_valid;
      out_key[2] = {58'd0, slv_resp.b.resp, slv_resp.b.id};
      in_rdy[3] = slv_resp.ar_ready; out_vld[3] = mst_req.ar_valid; out_key[3] = mst_req.ar.addr;
      in_rdy[4] = mst_req.r_ready;   out_vld[4] = slv_resp.r_valid; out_key[4] = slv_resp.r.data;
      for (int ch = 0; ch < 5; ch++) begin
        if (stall[ch] && (out_vld[ch] !== 1'b1 || out_key[ch] !== held_key[ch])) stab_err++;
        if (out_vld[ch] && snk_rdy[ch]) begin
          if (rp[ch] == wp[ch]) begin
            sb_err++;
          end else begin
            if (fifo[ch][rp[ch] % 8] !== out_key[ch]) sb_err++;
            rp[ch]++;
          end
          xfers[ch]++;
        end
        acc[ch] = src_vld[ch] && in_rdy[ch];
        if (acc[ch]) begin
          fifo[ch][wp[ch] % 8] = src_key[ch];
          wp[ch]++;
          if (wp[ch] - rp[ch] > 2) sb_err++;
        end
        stall[ch]    = out_vld[ch] && !snk_rdy[ch];
        held_key[ch] = out_key[ch];
      end
      tick();
    end
    checks++;
    if (sb_err !== 0) begin
      failures++; $display("FAIL rand_scoreboard: got %0d errors expected 0", sb_err);
    end
    checks++;
    if (stab_err !== 0) begin
      failures++; $display("FAIL rand_stability: got %0d violations expected 0", stab_err);
    end
    for (int ch = 0; ch < 5; ch++) begin
      checks++;
      if (xfers[ch] < 1000) begin
        failures++; $display("FAIL rand_throughput ch%0d: got %0d beats expected >=1000", ch, xfers[ch]);
      end
    end
  endtask

  task automatic test_bypass_midreset();
    apply_reset();
    slv_req.aw_valid  = 1'b1;
    slv_req.aw.addr   = 64'h1234;
    mst_resp.aw_ready = 1'b1;
    #1;
    checks++;
    if (mst_req_b.aw_valid !== 1'b1 || mst_req_b.aw.addr !== 64'h1234 || slv_resp_b.aw_ready !== 1'b1) begin
      failures++;
      $display("FAIL byp_pass: got valid=%b addr=%h ready=%b expected valid=1 addr=1234 ready=1",
               mst_req_b.aw_valid, mst_req_b.aw.addr, slv_resp_b.aw_ready);
    end
    mst_resp.aw_ready = 1'b0;
    #1;
    checks++;
    if (slv_resp_b.aw_ready !== 1'b0) begin
      failures++; $display("FAIL byp_ready: got %b expected 0", slv_resp_b.aw_ready);
    end
    slv_req.aw_valid = 1'b0;
    #1;
    checks++;
    if (mst_req_b.aw_valid !== 1'b0) begin
      failures++; $display("FAIL byp_valid_drop: got %b expected 0", mst_req_b.aw_valid);
    end
    mst_resp.w_ready = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 64'h11;
    tick();
    slv_req.w.data = 64'h22;
    tick();
    slv_req.w_valid = 1'b0;
    #1;
    checks++;
    if (slv_resp.w_ready !== 1'b0 || mst_req.w_valid !== 1'b1 || mst_req.w.data !== 64'h11) begin
      failures++;
      $display("FAIL mid_full: got ready=%b valid=%b data=%h expected ready=0 valid=1 data=11",
               slv_resp.w_ready, mst_req.w_valid, mst_req.w.data);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mst_req.w_valid !== 1'b0 || slv_resp.w_ready !== 1'b1 || mst_req.w.data !== 64'h0) begin
      failures++;
      $display("FAIL mid_reset_clear: got valid=%b ready=%b data=%h expected valid=0 ready=1 data=0",
               mst_req.w_valid, slv_resp.w_ready, mst_req.w.data);
    end
    tick();
    rst_n = 1'b1;
    mst_resp.w_ready = 1'b1;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 64'h33;
    tick();
    slv_req.w_valid = 1'b0;
    #1;
    checks++;
    if (mst_req.w_valid !== 1'b1 || mst_req.w.data !== 64'h33) begin
      failures++;
      $display("FAIL mid_recover: got valid=%b data=%h expected valid=1 data=33",
               mst_req.w_valid, mst_req.w.data);
    end
    tick();
    checks++;
    if (mst_req.w_valid !== 1'b0) begin
      failures++; $display("FAIL mid_recover_drain: got %b expected 0", mst_req.w_valid);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    slv_req  = '0;
    mst_resp = '0;
    test_reset();
    test_latency();
    test_backpressure();
    test_streaming();
    test_random();
    test_bypass_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
